// File: rtl/audio_pkg.sv
// audio_pkg: shared types and widths for the audio back end.
package audio_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} tone_state_t;
    localparam int PRESCALE_W = 10;
    localparam int SAMPLE_W = 16;
    localparam int CLK_HZ = 31_500_000;
endpackage

// File: rtl/tone_square_osc.sv
// tone_square_osc: prescaled square-wave oscillator whose pitch changes only at half-period boundaries.
module tone_square_osc import audio_pkg::*; #(
    parameter int HALF_DIV = 128
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] preScaleValue,
    output logic                  phase,
    output logic                  pitch_zero
);
    localparam int DW = $clog2(HALF_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
    // Divider starts one count ahead so tone_player's registered outputs land on the exact boundary.
    localparam logic [DW-1:0] DIV_START = DW'((HALF_DIV > 1) ? 1 : 0);
    logic [DW-1:0] div_cnt;
    logic [PRESCALE_W-1:0] half_cnt, pitch_q;
    logic tick, wrap;
    assign tick = div_cnt == DIV_LAST;
    assign wrap = tick && half_cnt == pitch_q - 1'b1;
    assign pitch_zero = pitch_q == '0;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_cnt <= '0;
            half_cnt <= '0;
            pitch_q <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            div_cnt <= DIV_START;
            half_cnt <= '0;
            pitch_q <= preScaleValue;
            phase <= 1'b1;
        end else if (pitch_zero) begin
            phase <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) half_cnt <= wrap ? '0 : half_cnt + 1'b1;
            if (wrap) begin
                phase <= ~phase;
                pitch_q <= preScaleValue;
            end
        end
    end
endmodule

// File: rtl/tone_player.sv
// tone_player: turns {preScaleValue, enabler} into an enveloped square tone (PCM sample and buzzer bit).
module tone_player import audio_pkg::*; #(
    parameter int HALF_DIV = 128,
    parameter int HOLD_CYCLES = 3_780_000,
    parameter int RELEASE_CYCLES = 787_500,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE = 16'h2000
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [PRESCALE_W-1:0] preScaleValue,
    input  logic                  enabler,
    output logic [SAMPLE_W-1:0]   audio_out,
    output logic                  square_out,
    output logic                  tone_active
);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [21:0] HOLD_LOAD = 22'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REL_LOAD = RW'(RELEASE_CYCLES - 1);
    tone_state_t state, state_d;
    logic [21:0] hold_cnt, hold_d;
    logic [RW-1:0] rel_cnt, rel_d;
    logic [1:0] step, step_d;
    logic restart, phase, pitch_zero, ph, pz;
    logic [SAMPLE_W-1:0] amp;
    assign restart = state == IDLE && enabler;
    tone_square_osc #(.HALF_DIV(HALF_DIV)) osc (
        .clk(clk),
        .resetN(resetN),
        .restart(restart),
        .preScaleValue(preScaleValue),
        .phase(phase),
        .pitch_zero(pitch_zero)
    );
    always_comb begin
        state_d = state;
        hold_d = hold_cnt;
        rel_d = rel_cnt;
        step_d = step;
        case (state)
            IDLE: if (enabler) begin
                state_d = PLAY;
                hold_d = HOLD_LOAD;
            end
            PLAY: if (enabler) hold_d = HOLD_LOAD;
            else if (hold_cnt == '0) begin
                state_d = RELEASE;
                step_d = '0;
                rel_d = REL_LOAD;
            end else hold_d = hold_cnt - 1'b1;
            RELEASE: if (enabler) begin
                state_d = PLAY;
                hold_d = HOLD_LOAD;
            end else if (rel_cnt != '0) rel_d = rel_cnt - 1'b1;
            else if (step == 2'd3) state_d = IDLE;
            else begin
                step_d = step + 1'b1;
                rel_d = REL_LOAD;
            end
            default: state_d = IDLE;
        endcase
    end
    // On note entry the oscillator is still restarting, so use the values it is about to load.
    assign ph = restart | phase;
    assign pz = restart ? preScaleValue == '0 : pitch_zero;
    assign amp = state_d == PLAY ? AMPLITUDE : AMPLITUDE >> ({1'b0, step_d} + 3'd1);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            hold_cnt <= '0;
            rel_cnt <= '0;
            step <= '0;
            audio_out <= '0;
            square_out <= 1'b0;
            tone_active <= 1'b0;
        end else begin
            state <= state_d;
            hold_cnt <= hold_d;
            rel_cnt <= rel_d;
            step <= step_d;
            tone_active <= state_d != IDLE;
            square_out <= ph && state_d != IDLE && !pz;
            audio_out <= (state_d == IDLE || pz) ? '0 : ph ? amp : -amp;
        end
    end
endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: randomized scoreboard bench for tone_player against an event-time reference model.
module tb_tone_player;
    localparam int HD = 4;
    localparam int HOLD = 1000;
    localparam int REL = 100;
    localparam logic [15:0] AMP = 16'h2000;

    logic clk = 0, resetN = 0, enabler = 0;
    logic [9:0] ps = '0;
    logic [15:0] audio_out;
    logic square_out, tone_active;

    tone_player #(.HALF_DIV(HD), .HOLD_CYCLES(HOLD), .RELEASE_CYCLES(REL), .AMPLITUDE(AMP)) dut (
        .clk(clk),
        .resetN(resetN),
        .preScaleValue(ps),
        .enabler(enabler),
        .audio_out(audio_out),
        .square_out(square_out),
        .tone_active(tone_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] audio;
        logic        sq;
        logic        act;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0, n_err = 0;
    int cyc = 0, t_last = 0, t_tog = 0, pitch = 0;
    bit active = 0, phase = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: the note is described by when it was last enabled and when the next
    // half-period boundary falls; the envelope is derived from the elapsed time alone.
    function automatic exp_t model_out();
        exp_t r;
        int e;
        logic [15:0] a;
        e = cyc - t_last;
        a = (e < HOLD) ? AMP : AMP >> ((e - HOLD) / REL + 1);
        r.act = active;
        r.sq = active && pitch != 0 && phase;
        r.audio = (!active || pitch == 0) ? 16'h0000 : phase ? a : 16'h0000 - a;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        if (resetN) begin
            cyc = cyc + 1;
            if (!active) begin
                if (enabler) begin
                    active = 1;
                    t_last = cyc;
                    pitch = int'(ps);
                    phase = 1;
                    t_tog = cyc + pitch * HD;
                end
            end else begin
                if (pitch != 0 && cyc == t_tog) begin
                    phase = !phase;
                    pitch = int'(ps);
                    t_tog = cyc + pitch * HD;
                end
                if (pitch == 0) phase = 1;
                if (enabler) t_last = cyc;
                else if (cyc - t_last >= HOLD + 4 * REL) active = 0;
            end
            exp_q.push_back(model_out());
        end
    end

    initial forever begin
        @(negedge resetN);
        active = 0;
        exp_q.delete();
    end

    initial forever begin
        exp_t x;
        @(negedge clk);
        if (resetN && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("audio_out", audio_out, x.audio);
            check("square_out", {15'b0, square_out}, {15'b0, x.sq});
            check("tone_active", {15'b0, tone_active}, {15'b0, x.act});
        end
    end

    task automatic note(input int p, input int len);
        ps = 10'(p);
        enabler = 1;
        repeat (len) @(negedge clk);
        enabler = 0;
    endtask

    // Pitch changes are only driven where they cannot straddle a half-period reload.
    task automatic run(input int n, input bit chg);
        repeat (n) begin
            @(negedge clk);
            if (chg && $urandom_range(0, 49) == 0 && (!active || t_tog > cyc + 1))
                ps = 10'($urandom_range(0, 20));
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, " audio"}, audio_out, 16'h0000);
        check({nm, " square"}, {15'b0, square_out}, 16'h0000);
        check({nm, " active"}, {15'b0, tone_active}, 16'h0000);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        resetN = 1;
        run(5, 0);
        note(3, 2);
        run(1500, 0);
        note(3, 1);
        run(HOLD + 2 * REL + 40, 0);
        note(3, 1);
        run(1500, 0);
        note(3, 1);
        run(4, 0);
        ps = 10'd5;
        run(1500, 0);
        note(0, 1);
        run(1500, 0);
        note(4, 1);
        run(50, 0);
        #2 resetN = 0;
        #1 check_zero("async reset");
        repeat (3) @(negedge clk);
        check_zero("held reset");
        resetN = 1;
        run(30, 0);
        for (int i = 0; i < 25; i++) begin
            note($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 15), $urandom_range(1, 3));
            run($urandom_range(0, 1600), 1);
        end
        run(1500, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
